bus_fifo_port: RTL

Parametrised FIFO slave on the PL-side 16-bit local bus (baddr/bwrdata/brddata/bwr/bstrobe, clocked by plclk). Fabric logic pushes words through a valid/ready port; software drains them through a memory-mapped DATA register and monitors the FIFO through status, count, threshold and drop-counter registers.
It generalises the fixed-register bus slaves in width, depth, base address and overflow mode. Several instances may share the bus; read data from all instances is ORed.

---
 rtl/bus_fifo_port.sv | 81 ++++++++
 1 files changed

// File: rtl/bus_fifo_port.sv
// bus_fifo_port: local-bus FIFO slave; fabric pushes via valid/ready, software drains through a DATA register
module bus_fifo_port #(
  parameter logic [15:0] BASE           = 16'h0040,
  parameter int          DW             = 16,
  parameter int          LOG2DEPTH      = 4,
  parameter bit          OVERFLOW_MODE  = 1'b0,
  parameter logic [15:0] THRESH_DEFAULT = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   baddr,
  input  logic [15:0]   bwrdata,
  input  logic          bwr,
  input  logic          bstrobe,
  output logic [15:0]   brddata,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          thresh_hit
);
  localparam int DEPTH = 1 << LOG2DEPTH;
  localparam int CW = LOG2DEPTH + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [LOG2DEPTH-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [15:0] thresh, drops;
  logic overflow, underflow;
  logic sel, rd_stb, wr_stb, empty, full, flush, pop_req, pop, push, drop, clr_ovf, clr_udf, drop_clr;
  logic [2:0] off;
  assign sel      = baddr[15:3] == BASE[15:3];
  assign off      = baddr[2:0];
  assign rd_stb   = bstrobe & ~bwr & sel;
  assign wr_stb   = bstrobe & bwr & sel;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign flush    = wr_stb && off == 3'd4 && bwrdata[0];
  assign clr_ovf  = wr_stb && off == 3'd1 && bwrdata[2];
  assign clr_udf  = wr_stb && off == 3'd1 && bwrdata[3];
  assign drop_clr = wr_stb && off == 3'd5;
  assign pop_req  = rd_stb && off == 3'd0;
  assign pop      = pop_req & ~empty & ~flush;
  assign in_ready = ~reset & (OVERFLOW_MODE | ~full);
  // a full FIFO in drop mode still accepts a word when the head leaves in the same cycle
  assign push     = in_valid & in_ready & ~flush & (~full | pop);
  assign drop     = in_valid & in_ready & ~flush & full & ~pop;
  always_comb begin
    brddata = '0;
    if (sel)
      case (off)
        3'd0:    brddata = empty ? '0 : 16'(mem[rptr]);
        3'd1:    brddata = {11'b0, thresh_hit, underflow, overflow, full, empty};
        3'd2:    brddata = 16'(count);
        3'd3:    brddata = thresh;
        3'd5:    brddata = drops;
        default: brddata = '0;
      endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      thresh     <= THRESH_DEFAULT;
      drops      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      thresh_hit <= 1'b0;
    end else begin
      rptr       <= flush ? '0 : rptr + LOG2DEPTH'(pop);
      wptr       <= flush ? '0 : wptr + LOG2DEPTH'(push);
      count      <= flush ? '0 : count + CW'(push) - CW'(pop);
      if (wr_stb && off == 3'd3) thresh <= bwrdata;
      drops      <= drop_clr ? 16'(drop) : drops + 16'(drop && drops != 16'hFFFF);
      overflow   <= drop | (overflow & ~clr_ovf);
      underflow  <= (pop_req & empty & ~flush) | (underflow & ~clr_udf);
      thresh_hit <= thresh != '0 && 16'(count) >= thresh;
    end
  end
endmodule
